// File: rtl/regfile_write_sequencer_if.sv
// Result-bus, drain and forwarding signals between the datapath and the
// register-file write sequencer.
interface regfile_write_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_reg;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              wb_stall;
  logic              RegWrite;
  logic [ADDR_W-1:0] WR;
  logic [DATA_W-1:0] WD;
  logic [ADDR_W-1:0] lk_reg1;
  logic [ADDR_W-1:0] lk_reg2;
  logic              hit1;
  logic              hit2;
  logic [DATA_W-1:0] fwd1;
  logic [DATA_W-1:0] fwd2;
  logic [CNT_W-1:0]  count;

  modport master (
    output in_valid, in_reg, in_data, flush, wb_stall, lk_reg1, lk_reg2,
    input  in_ready, RegWrite, WR, WD, hit1, hit2, fwd1, fwd2, count
  );

  modport slave (
    input  in_valid, in_reg, in_data, flush, wb_stall, lk_reg1, lk_reg2,
    output in_ready, RegWrite, WR, WD, hit1, hit2, fwd1, fwd2, count
  );
endinterface

// File: rtl/regfile_write_sequencer.sv
// In-order write queue in front of the 4x16 register file with forwarding lookups.
// Optional WB_COALESCE_EN: a push to the newest entry's register merges in place.
module regfile_write_sequencer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  regfile_write_sequencer_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [ADDR_W-1:0] reg_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic empty, full, pop, push_fire, alloc, merge, coal_hit;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // Flush takes priority over draining so no partial write escapes a discard.
  assign pop = !empty && !bus.wb_stall && !bus.flush;

`ifdef WB_COALESCE_EN
  logic [PTR_W-1:0] newest_ptr;
  assign newest_ptr = tail_q - PTR_W'(1);
  // A single entry that is leaving this cycle cannot absorb the new result.
  assign coal_hit = !empty && (reg_mem[newest_ptr] == bus.in_reg)
                    && !((count_q == CNT_W'(1)) && pop);
  assign bus.in_ready = !full || coal_hit;
`else
  assign coal_hit     = 1'b0;
  assign bus.in_ready = !full;
`endif

  assign push_fire = bus.in_valid && bus.in_ready && !bus.flush;
  assign alloc     = push_fire && !coal_hit;
  assign merge     = push_fire && coal_hit;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop)   head_d = head_q + PTR_W'(1);
      if (alloc) tail_d = tail_q + PTR_W'(1);
      count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: validity is implied by head/count.
  always_ff @(posedge clock) begin
    if (alloc) begin
      reg_mem[tail_q]  <= bus.in_reg;
      data_mem[tail_q] <= bus.in_data;
    end
`ifdef WB_COALESCE_EN
    if (merge) begin
      data_mem[newest_ptr] <= bus.in_data;
    end
`endif
  end

  assign bus.RegWrite = pop;
  assign bus.WR       = empty ? '0 : reg_mem[head_q];
  assign bus.WD       = empty ? '0 : data_mem[head_q];
  assign bus.count    = count_q;

  // Entries viewed by age: index 0 is the head (oldest), DEPTH-1 the youngest slot.
  logic [PTR_W-1:0] age_ptr   [DEPTH];
  logic             age_valid [DEPTH];
  logic             age_m1    [DEPTH];
  logic             age_m2    [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_age
      assign age_ptr[gi]   = head_q + PTR_W'(gi);
      assign age_valid[gi] = (CNT_W'(gi) < count_q);
      assign age_m1[gi]    = age_valid[gi] && (reg_mem[age_ptr[gi]] == bus.lk_reg1);
      assign age_m2[gi]    = age_valid[gi] && (reg_mem[age_ptr[gi]] == bus.lk_reg2);
    end
  endgenerate

  // Younger matches overwrite older ones, so the newest pending value wins.
  always_comb begin
    bus.hit1 = 1'b0;
    bus.hit2 = 1'b0;
    bus.fwd1 = '0;
    bus.fwd2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (age_m1[k]) begin
        bus.hit1 = 1'b1;
        bus.fwd1 = data_mem[age_ptr[k]];
      end
      if (age_m2[k]) begin
        bus.hit2 = 1'b1;
        bus.fwd2 = data_mem[age_ptr[k]];
      end
    end
  end

  logic unused_merge;
  assign unused_merge = merge;
endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Scoreboard bench: expected writes are queued at push time and popped as RegWrite appears.
module tb_regfile_write_sequencer;
  logic clock = 1'b0;
  logic reset_n = 1'b0;

`ifdef WB_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  regfile_write_sequencer_if #(.DATA_W(16), .ADDR_W(2), .CNT_W(3)) bus ();

  regfile_write_sequencer #(.DEPTH(4), .DATA_W(16), .ADDR_W(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Stand-in for the register file the sequencer feeds.
  logic [15:0] rf [4];
  always @(posedge clock) begin
    if (reset_n && bus.RegWrite) rf[bus.WR] <= bus.WD;
  end

  typedef struct {
    logic [1:0]  r;
    logic [15:0] d;
  } sb_ent_t;

  sb_ent_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    sb_ent_t e;
    if (reset_n && bus.RegWrite) begin
      if (sb.size() == 0) begin
        chk("spurious_wr", 32'(bus.RegWrite), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wr_reg", 32'(bus.WR), 32'(e.r));
        chk("wr_data", 32'(bus.WD), 32'(e.d));
        $display("write reg%0d <= %h (expected reg%0d <= %h)", bus.WR, bus.WD, e.r, e.d);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [1:0] r, input logic [15:0] d, input bit acc, input bit coal);
    bus.in_valid = 1'b1;
    bus.in_reg   = r;
    bus.in_data  = d;
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(acc));
    if (acc) begin
      if (coal) sb[sb.size()-1].d = d;
      else      sb.push_back('{r, d});
    end
    $display("push reg%0d = %h accept=%0d coalesce=%0d", r, d, acc, coal);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_reg   = '0;
    bus.in_data  = '0;
    bus.flush    = 1'b0;
    bus.wb_stall = 1'b0;
    bus.lk_reg1  = '0;
    bus.lk_reg2  = '0;

    // Reset state
    #2;
    chk("rst_regwrite", 32'(bus.RegWrite), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_wr", 32'(bus.WR), 32'd0);
    chk("rst_wd", 32'(bus.WD), 32'd0);
    chk("rst_hit1", 32'(bus.hit1), 32'd0);
    chk("rst_fwd1", 32'(bus.fwd1), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Single push, no stall: written one edge later
    push(2'd1, 16'hAAAA, 1'b1, 1'b0);
    chk("t1_count", 32'(bus.count), 32'd1);
    tick();
    chk("t1_rf1", 32'(rf[1]), 32'hAAAA);
    chk("t1_count0", 32'(bus.count), 32'd0);

    // Fill under stall, refuse fifth push, drain in order
    bus.wb_stall = 1'b1;
    push(2'd0, 16'h1111, 1'b1, 1'b0);
    push(2'd1, 16'h2222, 1'b1, 1'b0);
    push(2'd2, 16'h3333, 1'b1, 1'b0);
    push(2'd3, 16'h4444, 1'b1, 1'b0);
    chk("t2_count_full", 32'(bus.count), 32'd4);
    chk("t2_regwrite_stall", 32'(bus.RegWrite), 32'd0);
    push(2'd0, 16'h5555, 1'b0, 1'b0);
    chk("t2_count_still", 32'(bus.count), 32'd4);
    bus.wb_stall = 1'b0;
    drain(6);
    chk("t2_count0", 32'(bus.count), 32'd0);
    chk("t2_rf0", 32'(rf[0]), 32'h1111);
    chk("t2_rf3", 32'(rf[3]), 32'h4444);

    // Forwarding: newest pending value wins; in-flight push not visible
    bus.wb_stall = 1'b1;
    bus.lk_reg1  = 2'd2;
    bus.lk_reg2  = 2'd3;
    bus.in_valid = 1'b1;
    bus.in_reg   = 2'd2;
    bus.in_data  = 16'h5555;
    #1;
    chk("t3_hit1_preedge", 32'(bus.hit1), 32'd0);
    bus.in_valid = 1'b0;
    push(2'd2, 16'h5555, 1'b1, 1'b0);
    chk("t3_fwd1_first", 32'(bus.fwd1), 32'h5555);
    push(2'd2, 16'h6666, 1'b1, COAL);
    chk("t3_hit1", 32'(bus.hit1), 32'd1);
    chk("t3_fwd1", 32'(bus.fwd1), 32'h6666);
    chk("t3_hit2", 32'(bus.hit2), 32'd0);
    chk("t3_fwd2", 32'(bus.fwd2), 32'd0);
    chk("t3_count", 32'(bus.count), COAL ? 32'd1 : 32'd2);
    bus.wb_stall = 1'b0;
    drain(4);
    chk("t3_rf2", 32'(rf[2]), 32'h6666);
    chk("t3_hit1_gone", 32'(bus.hit1), 32'd0);

    // Full queue with pop: push waits for in_ready, then push+pop keeps count; pointers wrap
    bus.wb_stall = 1'b1;
    push(2'd0, 16'h00A0, 1'b1, 1'b0);
    push(2'd1, 16'h00A1, 1'b1, 1'b0);
    push(2'd2, 16'h00A2, 1'b1, 1'b0);
    push(2'd3, 16'h00A3, 1'b1, 1'b0);
    chk("t4_full", 32'(bus.count), 32'd4);
    bus.wb_stall = 1'b0;
    push(2'd0, 16'h00B0, 1'b0, 1'b0);
    chk("t4_after_pop", 32'(bus.count), 32'd3);
    push(2'd1, 16'h00B1, 1'b1, 1'b0);
    chk("t4_push_pop", 32'(bus.count), 32'd3);
    bus.wb_stall = 1'b1;
    push(2'd2, 16'h00B2, 1'b1, 1'b0);
    chk("t4_refill", 32'(bus.count), 32'd4);
    bus.lk_reg1 = 2'd3;
    #1;
    chk("t4_fwd_wrap", 32'(bus.fwd1), 32'h00A3);
    bus.wb_stall = 1'b0;
    drain(6);
    chk("t4_count0", 32'(bus.count), 32'd0);
    chk("t4_rf1", 32'(rf[1]), 32'h00B1);

    // Flush with coincident push: nothing written, coincident push dropped
    bus.wb_stall = 1'b1;
    push(2'd0, 16'h00C0, 1'b1, 1'b0);
    push(2'd1, 16'h00C1, 1'b1, 1'b0);
    push(2'd2, 16'h00C2, 1'b1, 1'b0);
    bus.wb_stall = 1'b0;
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_reg   = 2'd3;
    bus.in_data  = 16'h00EE;
    #1;
    chk("t5_regwrite_flush", 32'(bus.RegWrite), 32'd0);
    sb.delete();
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("t5_count0", 32'(bus.count), 32'd0);
    drain(2);
    chk("t5_rf0", 32'(rf[0]), 32'h00A0);
    chk("t5_rf2", 32'(rf[2]), 32'h00B2);
    chk("t5_rf3", 32'(rf[3]), 32'h00A3);

    // Push onto a single entry that is being popped: must allocate, not merge
    push(2'd1, 16'h0011, 1'b1, 1'b0);
    push(2'd1, 16'h0022, 1'b1, 1'b0);
    chk("t6_count", 32'(bus.count), 32'd1);
    drain(2);
    chk("t6_rf1", 32'(rf[1]), 32'h0022);

    // Reset mid-drain discards pending entries immediately
    bus.wb_stall = 1'b1;
    push(2'd0, 16'h00F0, 1'b1, 1'b0);
    push(2'd1, 16'h00F1, 1'b1, 1'b0);
    push(2'd2, 16'h00F2, 1'b1, 1'b0);
    bus.wb_stall = 1'b0;
    tick();
    reset_n = 1'b0;
    bus.lk_reg1 = 2'd1;
    #1;
    chk("t7_rst_regwrite", 32'(bus.RegWrite), 32'd0);
    chk("t7_rst_count", 32'(bus.count), 32'd0);
    chk("t7_rst_hit1", 32'(bus.hit1), 32'd0);
    chk("t7_rst_wd", 32'(bus.WD), 32'd0);
    sb.delete();
    drain(2);
    reset_n = 1'b1;
    drain(2);
    chk("t7_rf0", 32'(rf[0]), 32'h00F0);
    chk("t7_rf1", 32'(rf[1]), 32'h0022);
    chk("t7_in_ready", 32'(bus.in_ready), 32'd1);

`ifdef WB_COALESCE_EN
    // Coalescing: same-register pushes merge, even when full
    bus.wb_stall = 1'b1;
    push(2'd3, 16'h0001, 1'b1, 1'b0);
    push(2'd3, 16'h0002, 1'b1, 1'b1);
    chk("c_count1", 32'(bus.count), 32'd1);
    bus.lk_reg2 = 2'd3;
    #1;
    chk("c_fwd2", 32'(bus.fwd2), 32'h0002);
    push(2'd0, 16'h0100, 1'b1, 1'b0);
    push(2'd1, 16'h0101, 1'b1, 1'b0);
    push(2'd2, 16'h0222, 1'b1, 1'b0);
    chk("c_full", 32'(bus.count), 32'd4);
    push(2'd2, 16'h0333, 1'b1, 1'b1);
    chk("c_full_merge", 32'(bus.count), 32'd4);
    bus.wb_stall = 1'b0;
    drain(6);
    chk("c_rf3", 32'(rf[3]), 32'h0002);
    chk("c_rf2", 32'(rf[2]), 32'h0333);
`endif

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
